// File: rtl/bus_transfer_scheduler.sv
// Purpose : round-robin scheduler for register-to-register moves over the shared bus mux.
// Latency : accept edge E; select driven for HOLD_CYCLES cycles; one-cycle load/done pulse after edge E+HOLD_CYCLES.
// Backpress: requesters hold valid/src/dst until ready; ready is only offered in IDLE, one port at a time.
//
// Ports:
//   clk, clr_n                         clock, synchronous active-low reset
//   req_{a,b}_valid/_src/_dst/_ready   transfer request handshake per requester
//   done_{a,b}                         one-cycle pulse while that requester's transfer loads
//   gp_register_select                 bus mux source select (registered, holds last src)
//   reg_load                           one-hot destination load enable, nonzero only in LOAD
//   busy                               high whenever a transfer is in flight
module bus_transfer_scheduler #(
    parameter int NUM_REGS    = 16,
    parameter int SEL_W       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                req_a_valid,
    input  logic [SEL_W-1:0]    req_a_src,
    input  logic [SEL_W-1:0]    req_a_dst,
    output logic                req_a_ready,
    output logic                done_a,
    input  logic                req_b_valid,
    input  logic [SEL_W-1:0]    req_b_src,
    input  logic [SEL_W-1:0]    req_b_dst,
    output logic                req_b_ready,
    output logic                done_b,
    output logic [SEL_W-1:0]    gp_register_select,
    output logic [NUM_REGS-1:0] reg_load,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    localparam int              CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic            ID_A     = 1'b0;
    localparam logic            ID_B     = 1'b1;

    state_t             r_state;
    state_t             w_next;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_dst;
    logic               r_id;
    logic               r_last_grant;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_grant_a;
    logic               w_grant_b;
    logic               w_accept;

    // Contention goes to whichever port was not served last.
    always_comb begin
        w_grant_a = req_a_valid && (!req_b_valid || (r_last_grant == ID_B));
        w_grant_b = req_b_valid && (!req_a_valid || (r_last_grant == ID_A));
        w_accept  = (r_state == S_IDLE) && (w_grant_a || w_grant_b);
    end

    always_comb begin
        w_next      = r_state;
        req_a_ready = 1'b0;
        req_b_ready = 1'b0;
        reg_load    = '0;
        done_a      = 1'b0;
        done_b      = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy        = 1'b0;
                req_a_ready = w_grant_a;
                req_b_ready = w_grant_b;
                if (w_grant_a || w_grant_b) begin
                    w_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Counter reaching zero marks the last settle cycle.
                if (r_cnt == '0) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                reg_load = NUM_REGS'(1) << r_dst;
                done_a   = (r_id == ID_A);
                done_b   = (r_id == ID_B);
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_dst        <= '0;
            r_id         <= ID_A;
            r_last_grant <= ID_B;
            r_cnt        <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sel        <= w_grant_a ? req_a_src : req_b_src;
                r_dst        <= w_grant_a ? req_a_dst : req_b_dst;
                r_id         <= w_grant_b;
                r_last_grant <= w_grant_b;
                r_cnt        <= CNT_INIT;
            end else if ((r_state == S_DRIVE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Select is a register so it is glitch-free from the first DRIVE cycle
    // and keeps the last source while idle.
    assign gp_register_select = r_sel;

endmodule

// File: doc/bus_transfer_scheduler.md
Name: bus_transfer_scheduler

Overview:
- Sequences register-to-register transfers over the shared 16-source general-purpose bus mux.
- Two requesters (A, B) each submit a (src, dst) transfer over valid/ready. The block arbitrates round-robin between them.
- Drives the bus mux select for a programmable number of settle cycles, then pulses a one-hot load enable to the destination register.
- Sits between the control unit / microsequencer and the register-file-plus-bus datapath.

Parameters:
- NUM_REGS, 16, number of bus sources and destination registers; one-hot load width.
- SEL_W, 4, width of the source/destination index; must equal log2(NUM_REGS).
- HOLD_CYCLES, 1, bus-settle cycles with select driven before the load pulse; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- clr_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_a_valid  in  1  requester A has a transfer pending.
- req_a_src  in  SEL_W  requester A source register index.
- req_a_dst  in  SEL_W  requester A destination register index.
- req_a_ready  out  1  A's request is accepted at this edge.
- done_a  out  1  one-cycle pulse: A's transfer is loading this cycle.
- req_b_valid, req_b_src, req_b_dst, req_b_ready, done_b: same as A, for requester B.
- gp_register_select  out  SEL_W  bus mux source select.
- reg_load  out  NUM_REGS  one-hot destination load enable.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-low.
  - clr_n=0 at an edge forces state=IDLE, gp_register_select=0, reg_load=0, done_a=done_b=0, busy=0, last_grant=B.
  - Reset mid-transfer aborts the transfer. No load pulse and no done pulse are issued for it.
- States: IDLE, DRIVE, LOAD.
- Arbitration (combinational, only in IDLE; ready is 0 in DRIVE and LOAD):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the port that is not last_grant.
  - req_x_ready = (state==IDLE) && grant==x. At most one ready is high per cycle.
- Handshake:
  - A transfer is accepted at an edge where valid && ready.
  - src, dst and requester id are latched; last_grant updates to the accepted port; state goes to DRIVE; the hold counter loads HOLD_CYCLES-1.
  - Requesters hold valid/src/dst stable until ready. Dropping valid before acceptance withdraws the request without side effects.
- DRIVE:
  - gp_register_select = latched src (registered output, valid from the first DRIVE cycle). reg_load=0.
  - Counter decrements each cycle; at 0 the next state is LOAD.
- LOAD (exactly one cycle):
  - gp_register_select still = src. reg_load = 1 << dst. done_<id>=1.
  - Next state is IDLE.
- IDLE: reg_load=0, done=0. gp_register_select holds the last driven src.
- Timing:
  - Accept at edge 0; DRIVE for cycles 1..HOLD_CYCLES; LOAD at cycle HOLD_CYCLES+1; IDLE at cycle HOLD_CYCLES+2.
  - A new accept is possible at the end of that IDLE cycle, so throughput is one transfer per HOLD_CYCLES+2 cycles.
- src==dst is legal: normal sequence, and the register reloads its own value.
- reg_load is never multi-hot and never nonzero outside LOAD.
- busy = (state != IDLE).

Test Plan:
- Reset, then A: src=3, dst=7, HOLD_CYCLES=1. Expect req_a_ready=1 in the accept cycle; select=3 next cycle with reg_load=0; the following cycle reg_load=16'h0080, done_a=1; then IDLE with select still 3.
- A and B both valid from reset: A(src=1, dst=2), B(src=4, dst=5), both held. Expect A granted first (last_grant=B at reset), then B; loads 16'h0004 then 16'h0020, 3 cycles apart.
- A continuously valid with a new request each accept, B valid throughout. Expect strict alternation A, B, A, B. No starvation; never two readys high in one cycle.
- HOLD_CYCLES=4, B: src=15, dst=0. Expect select=15 for 4 DRIVE cycles with reg_load=0, then reg_load=16'h0001 with done_b=1; busy high for 5 cycles.
- clr_n=0 asserted during DRIVE of A(src=6, dst=9). Expect next edge: IDLE, reg_load=0, select=0, busy=0, and no done_a ever issued for that request.
- src=dst=12 request. Expect normal sequence with reg_load=16'h1000; select=12 during DRIVE and LOAD.
